// File: rtl/load_store_unit.sv
// load_store_unit: RV64 load/store to 64-bit doubleword memory, with read-modify-write for sub-doubleword stores
module load_store_unit #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  i_clk,
   input  logic                  i_arstn,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [2:0]            i_req_funct3,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_resp_valid,
   input  logic                  i_resp_ready,
   output logic [DATA_WIDTH-1:0] o_resp_rdata,
   output logic                  o_resp_err,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_we,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
   state_t state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0] f3_q;
   logic we_q;
   logic [DATA_WIDTH-1:0] wdata_q, word_q, mask, field, ext;
   logic [5:0] sh;
   logic accept, bad_in, bad_q;
   function automatic logic bad(input logic [2:0] a, input logic [2:0] f3, input logic we);
      logic [2:0] m;
      m = (3'd1 << f3[1:0]) - 3'd1;
      return |(a & m) || f3 == 3'b111 || (we && f3[2]);
   endfunction
   assign accept = i_req_valid && o_req_ready;
   assign bad_in = bad(i_req_addr[2:0], i_req_funct3, i_req_we);
   assign bad_q  = bad(addr_q[2:0], f3_q, we_q);
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         state   <= IDLE;
         addr_q  <= '0;
         f3_q    <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         word_q  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            addr_q  <= i_req_addr;
            f3_q    <= i_req_funct3;
            we_q    <= i_req_we;
            wdata_q <= i_req_wdata;
         end
         if (state == RD) word_q <= i_mem_rdata;
      end
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = bad_in ? RESP : (i_req_we && &i_req_funct3[1:0]) ? WR : RD;
         RD:      state_nxt = we_q ? WR : RESP;
         WR:      state_nxt = RESP;
         RESP:    if (i_resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   // One lane mask serves both store merge and load zero-extension; SD degenerates to a full replace
   assign sh    = {addr_q[2:0], 3'b000};
   assign mask  = f3_q[1:0] == 2'd0 ? 64'hFF : f3_q[1:0] == 2'd1 ? 64'hFFFF :
                  f3_q[1:0] == 2'd2 ? 64'hFFFF_FFFF : '1;
   assign field = word_q >> sh;
   assign ext   = f3_q[2] ? field & mask :
                  f3_q[1:0] == 2'd0 ? {{56{field[7]}}, field[7:0]} :
                  f3_q[1:0] == 2'd1 ? {{48{field[15]}}, field[15:0]} :
                  f3_q[1:0] == 2'd2 ? {{32{field[31]}}, field[31:0]} : field;
   assign o_req_ready  = state == IDLE;
   assign o_resp_valid = state == RESP;
   assign o_resp_err   = o_resp_valid && bad_q;
   assign o_resp_rdata = (o_resp_valid && !we_q && !bad_q) ? ext : '0;
   assign o_mem_we     = state == WR;
   assign o_mem_addr   = {addr_q[ADDR_WIDTH-1:3], 3'b000};
   assign o_mem_wdata  = o_mem_we ? (word_q & ~(mask << sh)) | ((wdata_q & mask) << sh) : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table vectors, hand sequences and random traffic checked against a byte-array memory model
module tb_load_store_unit;
   logic i_clk, i_arstn, i_req_valid, o_req_ready, i_req_we, o_resp_valid, i_resp_ready;
   logic o_resp_err, o_mem_we;
   logic [2:0] i_req_funct3;
   logic [9:0] i_req_addr, o_mem_addr;
   logic [63:0] i_req_wdata, o_resp_rdata, o_mem_wdata, i_mem_rdata;
   logic [63:0] mem [128];
   logic [7:0] refb [1024];
   int checks = 0, failures = 0, we_total = 0;

   load_store_unit dut (
      .i_clk(i_clk), .i_arstn(i_arstn), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_we(i_req_we), .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr),
      .i_req_wdata(i_req_wdata), .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
      .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err), .o_mem_addr(o_mem_addr),
      .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
   );

   initial i_clk = 0;
   always #5 i_clk = ~i_clk;
   assign i_mem_rdata = mem[o_mem_addr[9:3]];
   always @(posedge i_clk) if (o_mem_we) begin
      mem[o_mem_addr[9:3]] <= o_mem_wdata;
      we_total <= we_total + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic set_word(input int w, input logic [63:0] v);
      mem[w] <= v;
      for (int i = 0; i < 8; i++) refb[w*8+i] = v[8*i +: 8];
   endtask

   function automatic logic [63:0] ref_word(input int w);
      logic [63:0] v = 0;
      for (int i = 0; i < 8; i++) v |= 64'(refb[w*8+i]) << (8*i);
      return v;
   endfunction

   function automatic logic ref_err(input logic we, input logic [2:0] f3, input int a);
      int n = 1 << f3[1:0];
      return (a % n != 0) || f3 == 3'b111 || (we && f3[2]);
   endfunction

   function automatic logic [63:0] ref_load(input logic [2:0] f3, input int a);
      int n = 1 << f3[1:0];
      logic [63:0] v = 0;
      for (int i = 0; i < n; i++) v |= 64'(refb[a+i]) << (8*i);
      if (!f3[2] && n < 8 && v[8*n-1]) v |= ~64'h0 << (8*n);
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input int a, input logic [63:0] wd);
      for (int i = 0; i < (1 << f3[1:0]); i++) refb[a+i] = wd[8*i +: 8];
   endtask

   task automatic txn(input string nm, input logic we, input logic [2:0] f3, input logic [9:0] a,
                      input logic [63:0] wd, input logic [63:0] erd, input logic eer, input int elat,
                      input int ewec, input int hold, output logic [9:0] wa, output logic [63:0] wdv);
      int lat, wec, weat;
      chk($sformatf("%s.ready", nm), 64'(o_req_ready), 64'd1);
      i_req_valid = 1; i_req_we = we; i_req_funct3 = f3; i_req_addr = a; i_req_wdata = wd;
      i_resp_ready = 0;
      @(posedge i_clk);
      @(negedge i_clk);
      // scramble request inputs to prove the unit works from its latched copy
      i_req_valid = 0; i_req_we = ~we; i_req_funct3 = 3'($urandom); i_req_addr = 10'($urandom);
      i_req_wdata = {$urandom, $urandom};
      lat = 1; wec = 0; weat = 0; wa = 0; wdv = 0;
      while (!o_resp_valid && lat < 8) begin
         if (o_mem_we) begin wec++; weat = lat; wa = o_mem_addr; wdv = o_mem_wdata; end
         @(negedge i_clk);
         lat++;
      end
      chk($sformatf("%s.lat", nm), 64'(lat), 64'(elat));
      chk($sformatf("%s.wecnt", nm), 64'(wec), 64'(ewec));
      chk($sformatf("%s.rdata", nm), o_resp_rdata, erd);
      chk($sformatf("%s.err", nm), 64'(o_resp_err), 64'(eer));
      if (ewec != 0) begin
         chk($sformatf("%s.weat", nm), 64'(weat), 64'(elat - 1));
         chk($sformatf("%s.weaddr", nm), 64'(wa), 64'(a & 10'h3F8));
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge i_clk);
         chk($sformatf("%s.hold_valid", nm), 64'(o_resp_valid), 64'd1);
         chk($sformatf("%s.hold_rdata", nm), o_resp_rdata, erd);
         chk($sformatf("%s.hold_err", nm), 64'(o_resp_err), 64'(eer));
         chk($sformatf("%s.hold_ready", nm), 64'(o_req_ready), 64'd0);
      end
      i_resp_ready = 1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_resp_ready = 0;
      chk($sformatf("%s.done", nm), 64'(o_resp_valid), 64'd0);
   endtask

   task automatic mtxn(input string nm, input logic we, input logic [2:0] f3, input logic [9:0] a,
                       input logic [63:0] wd, input int hold);
      logic e;
      logic [63:0] rd, wdv;
      logic [9:0] wa;
      e  = ref_err(we, f3, int'(a));
      rd = (e || we) ? 64'd0 : ref_load(f3, int'(a));
      txn(nm, we, f3, a, wd, rd, e, e ? 1 : (!we || &f3[1:0]) ? 2 : 3, (!e && we) ? 1 : 0,
          hold, wa, wdv);
      if (!e && we) ref_store(f3, int'(a), wd);
   endtask

   typedef struct {
      logic we; logic [2:0] f3; logic [9:0] a; logic [63:0] rd; logic er; int lat;
   } vec_t;
   vec_t tv [12];

   initial begin
      logic [9:0] wa;
      logic [63:0] wdv;
      int wt;
      tv[0]  = '{1'b0, 3'b000, 10'h013, 64'h0000000000000044, 1'b0, 2};
      tv[1]  = '{1'b0, 3'b000, 10'h017, 64'hFFFFFFFFFFFFFF88, 1'b0, 2};
      tv[2]  = '{1'b0, 3'b100, 10'h017, 64'h0000000000000088, 1'b0, 2};
      tv[3]  = '{1'b0, 3'b010, 10'h014, 64'hFFFFFFFF88776655, 1'b0, 2};
      tv[4]  = '{1'b0, 3'b010, 10'h012, 64'h0, 1'b1, 1};
      tv[5]  = '{1'b1, 3'b100, 10'h010, 64'h0, 1'b1, 1};
      tv[6]  = '{1'b0, 3'b001, 10'h016, 64'hFFFFFFFFFFFF8877, 1'b0, 2};
      tv[7]  = '{1'b0, 3'b101, 10'h016, 64'h0000000000008877, 1'b0, 2};
      tv[8]  = '{1'b0, 3'b110, 10'h014, 64'h0000000088776655, 1'b0, 2};
      tv[9]  = '{1'b0, 3'b011, 10'h010, 64'h8877665544332211, 1'b0, 2};
      tv[10] = '{1'b0, 3'b111, 10'h010, 64'h0, 1'b1, 1};
      tv[11] = '{1'b0, 3'b011, 10'h013, 64'h0, 1'b1, 1};
      i_arstn = 0; i_req_valid = 0; i_req_we = 0; i_req_funct3 = 0; i_req_addr = 0;
      i_req_wdata = 0; i_resp_ready = 0;
      for (int i = 0; i < 128; i++) set_word(i, {$urandom, $urandom});
      set_word(2, 64'h8877665544332211);
      #1;
      chk("rst.ready", 64'(o_req_ready), 64'd1);
      chk("rst.valid", 64'(o_resp_valid), 64'd0);
      chk("rst.we", 64'(o_mem_we), 64'd0);
      chk("rst.addr", 64'(o_mem_addr), 64'd0);
      chk("rst.wdata", o_mem_wdata, 64'd0);
      chk("rst.rdata", o_resp_rdata, 64'd0);
      repeat (2) @(negedge i_clk);
      i_arstn = 1;
      for (int i = 0; i < 12; i++)
         txn($sformatf("tv%0d", i), tv[i].we, tv[i].f3, tv[i].a, 64'h0, tv[i].rd, tv[i].er,
             tv[i].lat, tv[i].we && !tv[i].er ? 1 : 0, 0, wa, wdv);
      txn("sh", 1'b1, 3'b001, 10'h012, 64'h123456789ABCBEEF, 64'h0, 1'b0, 3, 1, 0, wa, wdv);
      chk("sh.wdata", wdv, 64'h88776655BEEF2211);
      ref_store(3'b001, 'h12, 64'h123456789ABCBEEF);
      chk("sh.mem", mem[2], 64'h88776655BEEF2211);
      txn("sd", 1'b1, 3'b011, 10'h018, 64'h0123456789ABCDEF, 64'h0, 1'b0, 2, 1, 0, wa, wdv);
      chk("sd.wdata", wdv, 64'h0123456789ABCDEF);
      ref_store(3'b011, 'h18, 64'h0123456789ABCDEF);
      mtxn("ld18", 1'b0, 3'b011, 10'h018, 64'h0, 0);
      mtxn("bp", 1'b0, 3'b000, 10'h017, 64'h0, 5);
      mtxn("bp_next", 1'b0, 3'b010, 10'h014, 64'h0, 0);
      // reset landing in the RD cycle of an SB must abort the write
      i_req_valid = 1; i_req_we = 1; i_req_funct3 = 3'b000; i_req_addr = 10'h011;
      i_req_wdata = 64'h5A;
      @(posedge i_clk);
      @(negedge i_clk);
      i_req_valid = 0;
      chk("ab.rdaddr", 64'(o_mem_addr), 64'h010);
      wt = we_total;
      i_arstn = 0;
      #1;
      chk("ab.ready", 64'(o_req_ready), 64'd1);
      chk("ab.valid", 64'(o_resp_valid), 64'd0);
      chk("ab.err", 64'(o_resp_err), 64'd0);
      chk("ab.we", 64'(o_mem_we), 64'd0);
      chk("ab.addr", 64'(o_mem_addr), 64'd0);
      chk("ab.wdata", o_mem_wdata, 64'd0);
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_arstn = 1;
      chk("ab.wecount", 64'(we_total), 64'(wt));
      chk("ab.mem", mem[2], ref_word(2));
      mtxn("ab.ld", 1'b0, 3'b011, 10'h010, 64'h0, 0);
      for (int i = 0; i < 80; i++)
         mtxn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              10'($urandom_range(0, 63)), {$urandom, $urandom}, $urandom_range(0, 2));
      for (int w = 0; w < 8; w++) chk($sformatf("mem%0d", w), mem[w], ref_word(w));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's memory stage and the 64-bit data memory.
- Converts RV64 load/store requests (byte, half, word, double; signed/unsigned) into doubleword-aligned memory accesses.
- Sub-doubleword stores use a read-modify-write sequence because the data memory only writes whole 64-bit words.
- Sign- or zero-extends load data and flags misaligned or illegal accesses.

Parameters:
- DATA_WIDTH, 64, data path width; only 64 is supported.
- ADDR_WIDTH, 10, byte address width.

Ports:
- i_clk, input, 1, clock; all state changes on its rising edge.
- i_arstn, input, 1, asynchronous active-low reset.
- i_req_valid, input, 1, core request valid.
- o_req_ready, output, 1, unit can accept a request; high only in IDLE.
- i_req_we, input, 1, 1 = store, 0 = load.
- i_req_funct3, input, 3, RV64 funct3 size/sign code.
- i_req_addr, input, ADDR_WIDTH, byte address.
- i_req_wdata, input, DATA_WIDTH, store data, right-aligned.
- o_resp_valid, output, 1, response valid; high only in RESP.
- i_resp_ready, input, 1, core accepts the response.
- o_resp_rdata, output, DATA_WIDTH, extended load data; 0 for stores and errors.
- o_resp_err, output, 1, misaligned or illegal request; no memory side effect occurred.
- o_mem_addr, output, ADDR_WIDTH, doubleword-aligned address: latched address with bits [2:0] forced to 0.
- o_mem_we, output, 1, memory write enable.
- o_mem_wdata, output, DATA_WIDTH, merged write data.
- i_mem_rdata, input, DATA_WIDTH, combinational read data for o_mem_addr.

Behaviour:
- Request handshake:
  - A request is accepted on an edge where i_req_valid && o_req_ready.
  - addr, funct3, we and wdata are latched; the core may change its inputs afterwards.
- Size and signedness come from funct3[1:0]: 0 = byte, 1 = half, 2 = word, 3 = double. funct3[2] = 1 means unsigned.
- Legality check on the latched request:
  - Misaligned if addr[2:0] is not a multiple of the access size.
  - Illegal if funct3 = 111, or if the request is a store with funct3[2] = 1.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE -> RESP with err = 1 for misaligned/illegal requests; no memory access.
  - IDLE -> WR for a legal SD (full doubleword store).
  - IDLE -> RD for all other legal requests.
  - RD: o_mem_addr driven; i_mem_rdata captured into an internal word register at the end of the cycle. Loads go to RESP; sub-doubleword stores go to WR.
  - WR: o_mem_we = 1 for exactly one cycle. o_mem_wdata is:
    - i_req_wdata for SD;
    - otherwise the captured word with the selected byte lanes replaced. Lanes start at addr[2:0]*8 bits and take the low 8/16/32 bits of wdata.
    - WR -> RESP.
  - RESP: o_resp_valid = 1; holds all response outputs stable until i_resp_ready; then -> IDLE.
- Load data:
  - Select the field at offset addr[2:0] from the captured word.
  - Sign-extend to 64 bits when funct3[2] = 0, else zero-extend.
  - LD returns the word unchanged.
- Latency (request accepted on edge N):
  - Load: response valid from cycle N+2.
  - SD: write in cycle N+1, response from N+2.
  - Sub-doubleword store: read in N+1, write in N+2, response from N+3.
  - Error: response from N+1.
- o_mem_we and o_resp_valid are decoded directly from the state register, so reset clears them immediately.
- Reset (i_arstn low, asynchronous):
  - State = IDLE; all latched registers and the captured word = 0.
  - Outputs: o_req_ready = 1, o_resp_valid = 0, o_resp_rdata = 0, o_resp_err = 0, o_mem_we = 0, o_mem_addr = 0, o_mem_wdata = 0.
  - Reset during RD or WR aborts the operation; no write occurs after reset asserts.
  - The first acceptance is possible on the first rising edge after deassertion.
- A new request is not accepted in the same cycle a response is consumed: RESP -> IDLE takes one edge.
- Only the single latched request is ever in flight, so no same-address hazards exist.

Test Plan:
- Memory doubleword at 0x010 = 0x8877665544332211 for all loads below.
  - LB at 0x013 -> rdata 0x0000000000000044, err 0, valid at N+2.
  - LB at 0x017 -> 0xFFFFFFFFFFFFFF88.
  - LBU at 0x017 -> 0x0000000000000088.
  - LW at 0x014 -> 0xFFFFFFFF88776655.
- SH wdata 0x...BEEF at 0x012, starting from the word above:
  - exactly one o_mem_we pulse at N+2 with addr 0x010, wdata 0x88776655BEEF2211;
  - response at N+3 with rdata 0.
- SD 0x0123456789ABCDEF at 0x018 -> no RD cycle; we pulse at N+1 with that data; response at N+2.
- LW at 0x012 (misaligned), and store with funct3 = 100 (illegal) -> o_resp_err = 1 at N+1, o_mem_we never asserts, rdata 0.
- Response backpressure: hold i_resp_ready low for 5 cycles -> valid, rdata and err stay stable and o_req_ready stays 0; accept the response, then the next request is accepted one cycle later.
- Assert i_arstn low during the RD cycle of an SB:
  - o_mem_we never pulses and memory is unchanged;
  - outputs take their reset values immediately;
  - after release, an LD at 0x010 returns the original word.
